// File: rtl/stack_cpu_p_pkg.sv
// Shared definitions for the stack_cpu_p core: opcodes, fault codes, FSM states, stack ops.
// Latency: n/a (constants, types and one combinational helper only).
// Backpressure: n/a.
package stack_cpu_p_pkg;

    // Opcodes live in the top four bits of an instruction word.
    localparam logic [3:0] OP_PUSHC = 4'h0;
    localparam logic [3:0] OP_PUSH  = 4'h1;
    localparam logic [3:0] OP_POP   = 4'h2;
    localparam logic [3:0] OP_JUMP  = 4'h3;
    localparam logic [3:0] OP_JZ    = 4'h4;
    localparam logic [3:0] OP_JS    = 4'h5;
    localparam logic [3:0] OP_ADD   = 4'h6;
    localparam logic [3:0] OP_SUB   = 4'h7;
    localparam logic [3:0] OP_DUP   = 4'h8;
    localparam logic [3:0] OP_SWAP  = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OVF  = 2'd1;
    localparam logic [1:0] FC_UNF  = 2'd2;
    localparam logic [1:0] FC_ILL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_t;

    typedef enum logic [2:0] {
        SOP_NONE,
        SOP_PUSH,
        SOP_POP,
        SOP_SWAP,
        SOP_POP_REPL    // drop top, overwrite the new top: a two-operand ALU result
    } stk_op_t;

    // Signed overflow of r = b + a (is_sub=0) or r = b - a (is_sub=1), from sign bits only.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        if (is_sub)
            return (b_msb != a_msb) && (r_msb != b_msb);
        else
            return (b_msb == a_msb) && (r_msb != b_msb);
    endfunction

endpackage

// File: rtl/stack_cpu_p_stack_file.sv
// Operand stack: push/pop/swap/pop-and-replace-top; combinational top/next-to-top reads.
// Latency: ops take effect on the clock edge; reads reflect the current count immediately.
// Backpressure: none; the caller must not push when full or pop/swap below the needed depth.
// Ports: clk, rst (sync, active-high, clears count only), op/wdata (command),
//        top/nxt (entries sp-1 / sp-2, 0 when absent), count, full, empty.
module stack_file
    import stack_cpu_p_pkg::*;
#(
    parameter int DW = 8,
    parameter int SD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  stk_op_t                op,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          top,
    output logic [DW-1:0]          nxt,
    output logic [$clog2(SD):0]    count,
    output logic                   full,
    output logic                   empty
);

    localparam int SW  = $clog2(SD);
    localparam int CW  = SW + 1;

    logic [DW-1:0] stk_q [SD];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] idx_push, idx_top, idx_nxt;

    // Indices wrap into SW bits; they are only used when the count makes them valid.
    assign idx_push = cnt_q[SW-1:0];
    assign idx_top  = SW'(cnt_q - CW'(1));
    assign idx_nxt  = SW'(cnt_q - CW'(2));

    assign top   = (cnt_q > CW'(0)) ? stk_q[idx_top] : '0;
    assign nxt   = (cnt_q > CW'(1)) ? stk_q[idx_nxt] : '0;
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(SD));
    assign empty = (cnt_q == CW'(0));

    always_comb begin
        cnt_d = cnt_q;
        case (op)
            SOP_PUSH:     cnt_d = cnt_q + CW'(1);
            SOP_POP,
            SOP_POP_REPL: cnt_d = cnt_q - CW'(1);
            default:      cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Entry storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (op)
                SOP_PUSH:     stk_q[idx_push] <= wdata;
                SOP_SWAP: begin
                    stk_q[idx_top] <= nxt;
                    stk_q[idx_nxt] <= top;
                end
                SOP_POP_REPL: stk_q[idx_nxt] <= wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stack_cpu_p.sv
// Parametrised stack-machine core with unified memory, program-load port and fault detection.
// Latency: 2 cycles per instruction (FETCH, EXEC); results visible after the EXEC edge.
// Backpressure: none; load_en/run only honoured in IDLE, start overrides everything.
// Ports: clk, start (sync reset), load_en/load_addr/load_data (IDLE-only memory write),
//        run (IDLE -> FETCH), pc_out, sp_out, tos, zf/sf/vf, retire, halted, fault, fault_code.
module stack_cpu_p
    import stack_cpu_p_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int SD = 8
) (
    input  logic                   clk,
    input  logic                   start,
    input  logic                   load_en,
    input  logic [AW-1:0]          load_addr,
    input  logic [DW-1:0]          load_data,
    input  logic                   run,
    output logic [AW-1:0]          pc_out,
    output logic [$clog2(SD):0]    sp_out,
    output logic [DW-1:0]          tos,
    output logic                   zf,
    output logic                   sf,
    output logic                   vf,
    output logic                   retire,
    output logic                   halted,
    output logic                   fault,
    output logic [1:0]             fault_code
);

    localparam int CW = $clog2(SD) + 1;

    logic [DW-1:0] mem_q [2**AW];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [3:0]    opc_q, opc_d;
    logic [DW-1:0] opnd_q, opnd_d;
    logic          zf_q, zf_d, sf_q, sf_d, vf_q, vf_d;
    logic          retire_q, retire_d;
    logic [1:0]    fault_code_q, fault_code_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    stk_op_t       stk_op;
    logic [DW-1:0] stk_wdata, stk_top, stk_nxt;
    logic [CW-1:0] stk_cnt;
    logic          stk_full, stk_empty, stk_has2;

    logic [1:0]    flt;
    logic          taken;
    logic [DW-1:0] alu_res;

    stack_file #(.DW(DW), .SD(SD)) u_stack (
        .clk   (clk),
        .rst   (start),
        .op    (stk_op),
        .wdata (stk_wdata),
        .top   (stk_top),
        .nxt   (stk_nxt),
        .count (stk_cnt),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign stk_has2 = (stk_cnt > CW'(1));
    assign alu_res  = (opc_q == OP_SUB) ? (stk_nxt - stk_top) : (stk_nxt + stk_top);
    assign taken    = (opc_q == OP_JZ) ? zf_q : sf_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        opc_d        = opc_q;
        opnd_d       = opnd_q;
        zf_d         = zf_q;
        sf_d         = sf_q;
        vf_d         = vf_q;
        retire_d     = 1'b0;
        fault_code_d = fault_code_q;
        mem_we       = 1'b0;
        mem_waddr    = load_addr;
        mem_wdata    = load_data;
        stk_op       = SOP_NONE;
        stk_wdata    = opnd_q;
        flt          = FC_NONE;

        case (state_q)
            ST_IDLE: begin
                mem_we = load_en;
                if (run)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                opc_d   = mem_q[pc_q][DW-1:DW-4];
                opnd_d  = mem_q[pc_q + AW'(1)];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opc_q)
                    OP_PUSHC, OP_PUSH: begin
                        if (stk_full) flt = FC_OVF;
                        stk_op    = SOP_PUSH;
                        stk_wdata = (opc_q == OP_PUSH) ? mem_q[opnd_q[AW-1:0]] : opnd_q;
                        pc_d      = pc_q + AW'(2);
                    end
                    OP_POP: begin
                        if (stk_empty) flt = FC_UNF;
                        stk_op    = SOP_POP;
                        mem_we    = 1'b1;
                        mem_waddr = opnd_q[AW-1:0];
                        mem_wdata = stk_top;
                        pc_d      = pc_q + AW'(2);
                    end
                    OP_JUMP: begin
                        if (stk_empty) flt = FC_UNF;
                        stk_op = SOP_POP;
                        pc_d   = stk_top[AW-1:0];
                    end
                    OP_JZ, OP_JS: begin
                        // Not-taken never touches the stack, so it cannot underflow.
                        if (taken) begin
                            if (stk_empty) flt = FC_UNF;
                            stk_op = SOP_POP;
                            pc_d   = stk_top[AW-1:0];
                        end else begin
                            pc_d   = pc_q + AW'(1);
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (!stk_has2) flt = FC_UNF;
                        stk_op    = SOP_POP_REPL;
                        stk_wdata = alu_res;
                        zf_d      = (alu_res == '0);
                        sf_d      = alu_res[DW-1];
                        vf_d      = signed_ovf(stk_top[DW-1], stk_nxt[DW-1],
                                               alu_res[DW-1], opc_q == OP_SUB);
                        pc_d      = pc_q + AW'(1);
                    end
                    OP_DUP: begin
                        if (stk_empty)     flt = FC_UNF;
                        else if (stk_full) flt = FC_OVF;
                        stk_op    = SOP_PUSH;
                        stk_wdata = stk_top;
                        pc_d      = pc_q + AW'(1);
                    end
                    OP_SWAP: begin
                        if (!stk_has2) flt = FC_UNF;
                        stk_op = SOP_SWAP;
                        pc_d   = pc_q + AW'(1);
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        flt = FC_ILL;
                    end
                endcase

                // A faulting instruction must leave no architectural trace.
                if (flt != FC_NONE) begin
                    stk_op       = SOP_NONE;
                    mem_we       = 1'b0;
                    pc_d         = pc_q;
                    zf_d         = zf_q;
                    sf_d         = sf_q;
                    vf_d         = vf_q;
                    state_d      = ST_FAULT;
                    fault_code_d = flt;
                end else begin
                    retire_d     = 1'b1;
                end
            end
            ST_HALT, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            zf_q         <= 1'b0;
            sf_q         <= 1'b0;
            vf_q         <= 1'b0;
            retire_q     <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            zf_q         <= zf_d;
            sf_q         <= sf_d;
            vf_q         <= vf_d;
            retire_q     <= retire_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Latched instruction fields need no reset: FETCH always precedes EXEC.
    always_ff @(posedge clk) begin
        opc_q  <= opc_d;
        opnd_q <= opnd_d;
    end

    // start also squashes an in-flight POP write.
    always_ff @(posedge clk) begin
        if (mem_we && !start)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign pc_out     = pc_q;
    assign sp_out     = stk_cnt;
    assign tos        = stk_top;
    assign zf         = zf_q;
    assign sf         = sf_q;
    assign vf         = vf_q;
    assign retire     = retire_q;
    assign halted     = (state_q == ST_HALT);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_stack_cpu_p.sv
// Directed self-checking bench for stack_cpu_p (DW=8, AW=8, SD=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_stack_cpu_p;

    localparam logic [7:0] I_PUSHC = 8'h00;
    localparam logic [7:0] I_PUSH  = 8'h10;
    localparam logic [7:0] I_POP   = 8'h20;
    localparam logic [7:0] I_JUMP  = 8'h30;
    localparam logic [7:0] I_JZ    = 8'h40;
    localparam logic [7:0] I_JS    = 8'h50;
    localparam logic [7:0] I_ADD   = 8'h60;
    localparam logic [7:0] I_SUB   = 8'h70;
    localparam logic [7:0] I_DUP   = 8'h80;
    localparam logic [7:0] I_SWAP  = 8'h90;
    localparam logic [7:0] I_ILL   = 8'hC0;
    localparam logic [7:0] I_HALT  = 8'hF0;

    logic       clk = 1'b0;
    logic       start = 1'b1;
    logic       load_en = 1'b0;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       run = 1'b0;
    logic [7:0] pc_out;
    logic [3:0] sp_out;
    logic [7:0] tos;
    logic       zf, sf, vf, retire, halted, fault;
    logic [1:0] fault_code;

    int n_run  = 0;
    int n_fail = 0;
    int ret_cnt = 0;
    int r0 = 0;

    always #5 clk = ~clk;

    stack_cpu_p #(.DW(8), .AW(8), .SD(8)) dut (
        .clk        (clk),
        .start      (start),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .run        (run),
        .pc_out     (pc_out),
        .sp_out     (sp_out),
        .tos        (tos),
        .zf         (zf),
        .sf         (sf),
        .vf         (vf),
        .retire     (retire),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always @(negedge clk) if (retire === 1'b1) ret_cnt <= ret_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end aligned to a falling edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ld(input logic [7:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic go(input string tag);
        int k;
        k = 0;
        r0 = ret_cnt;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        while (!(halted || fault) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, {31'b0, halted | fault}, 1);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_start();

        // Reset state
        chk("rst_pc", pc_out, 0);
        chk("rst_sp", sp_out, 0);
        chk("rst_tos", tos, 0);
        chk("rst_flags", {zf, sf, vf}, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fc", fault_code, 0);

        // 1: PUSHC 3, PUSHC 2, SUB, HALT with exact cycle timing
        ld(0, I_PUSHC); ld(1, 8'd3); ld(2, I_PUSHC); ld(3, 8'd2); ld(4, I_SUB); ld(5, I_HALT);
        r0 = ret_cnt;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (7) @(negedge clk);
        chk("t1_not_yet_halted", halted, 0);
        @(negedge clk);
        chk("t1_halted", halted, 1);
        @(negedge clk);
        chk("t1_tos", tos, 1);
        chk("t1_sp", sp_out, 1);
        chk("t1_flags", {zf, sf, vf}, 0);
        chk("t1_retires", ret_cnt - r0, 4);
        chk("t1_pc", pc_out, 5);

        // 2: taken JZ to 20 (SUB leaves 0 on the stack, JZ pops only its target)
        do_start();
        ld(0, I_PUSHC); ld(1, 8'd2); ld(2, I_PUSHC); ld(3, 8'd2); ld(4, I_SUB);
        ld(5, I_PUSHC); ld(6, 8'd20); ld(7, I_JZ); ld(20, I_HALT);
        go("t2");
        chk("t2_zf", zf, 1);
        chk("t2_pc", pc_out, 20);
        chk("t2_sp", sp_out, 1);
        chk("t2_tos", tos, 0);
        chk("t2_halted", halted, 1);
        chk("t2_retires", ret_cnt - r0, 6);

        // 3: nine pushes into an 8-deep stack
        do_start();
        for (int i = 0; i < 9; i++) begin
            ld(8'(2 * i), I_PUSHC);
            ld(8'(2 * i + 1), 8'(i + 1));
        end
        go("t3");
        chk("t3_fault", fault, 1);
        chk("t3_fc", fault_code, 1);
        chk("t3_sp", sp_out, 8);
        chk("t3_pc", pc_out, 16);
        chk("t3_tos", tos, 8);
        chk("t3_retires", ret_cnt - r0, 8);

        // 4: ADD with one entry underflows; zf from an earlier SUB must survive
        do_start();
        ld(0, I_PUSHC); ld(1, 8'd1); ld(2, I_PUSHC); ld(3, 8'd1); ld(4, I_SUB);
        ld(5, I_POP); ld(6, 8'd60); ld(7, I_PUSHC); ld(8, 8'd5); ld(9, I_ADD);
        go("t4");
        chk("t4_fc", fault_code, 2);
        chk("t4_sp", sp_out, 1);
        chk("t4_tos", tos, 5);
        chk("t4_flags", {zf, sf, vf}, 3'b100);
        chk("t4_pc", pc_out, 9);
        chk("t4_halted", halted, 0);

        // 5: signed overflow, DUP, SWAP, POP to memory
        do_start();
        ld(0, I_PUSHC); ld(1, 8'h7F); ld(2, I_PUSHC); ld(3, 8'h01); ld(4, I_ADD);
        ld(5, I_DUP); ld(6, I_SWAP); ld(7, I_POP); ld(8, 8'd40); ld(9, I_HALT);
        go("t5");
        chk("t5_tos", tos, 8'h80);
        chk("t5_sp", sp_out, 1);
        chk("t5_flags", {zf, sf, vf}, 3'b011);
        chk("t5_retires", ret_cnt - r0, 7);
        chk("t5_pc", pc_out, 9);
        // read mem[40] back through the core; memory survives start
        do_start();
        ld(0, I_PUSH); ld(1, 8'd40); ld(2, I_HALT);
        go("t5r");
        chk("t5_mem40", tos, 8'h80);

        // taken JZ with empty stack underflows
        do_start();
        ld(0, I_PUSHC); ld(1, 8'd1); ld(2, I_PUSHC); ld(3, 8'd1); ld(4, I_SUB);
        ld(5, I_POP); ld(6, 8'd30); ld(7, I_JZ);
        go("tjz");
        chk("tjz_fc", fault_code, 2);
        chk("tjz_pc", pc_out, 7);
        chk("tjz_sp", sp_out, 0);

        // JUMP, then not-taken JS on an empty stack
        do_start();
        ld(0, I_PUSHC); ld(1, 8'd6); ld(2, I_JUMP); ld(3, I_ILL);
        ld(6, I_JS); ld(7, I_HALT);
        go("tjmp");
        chk("tjmp_halted", halted, 1);
        chk("tjmp_pc", pc_out, 7);
        chk("tjmp_sp", sp_out, 0);

        // SWAP ordering, then an illegal opcode
        do_start();
        ld(0, I_PUSHC); ld(1, 8'd1); ld(2, I_PUSHC); ld(3, 8'd2); ld(4, I_SWAP); ld(5, I_ILL);
        go("till");
        chk("till_fc", fault_code, 3);
        chk("till_pc", pc_out, 5);
        chk("till_tos", tos, 1);
        chk("till_sp", sp_out, 2);
        chk("till_retires", ret_cnt - r0, 3);

        // 6: start during EXEC of POP; load_en while running is ignored
        do_start();
        ld(50, 8'h11); ld(51, 8'h55);
        ld(0, I_PUSHC); ld(1, 8'h22); ld(2, I_POP); ld(3, 8'd50); ld(4, I_HALT);
        r0 = ret_cnt;
        run = 1'b1;
        @(negedge clk);                 // run sampled, now FETCH
        run = 1'b0;
        @(negedge clk);                 // EXEC of PUSHC
        load_addr = 8'd51;
        load_data = 8'h44;
        load_en   = 1'b1;
        @(negedge clk);                 // FETCH of POP
        load_en   = 1'b0;
        @(negedge clk);                 // EXEC of POP
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_pc", pc_out, 0);
        chk("t6_sp", sp_out, 0);
        chk("t6_halted", halted, 0);
        chk("t6_fault", fault, 0);
        chk("t6_retire", retire, 0);
        @(negedge clk);
        chk("t6_retires", ret_cnt - r0, 1);
        // 0x11 - 0x55 = 0xBC only if neither the POP nor the stray load landed
        ld(0, I_PUSH); ld(1, 8'd50); ld(2, I_PUSH); ld(3, 8'd51); ld(4, I_SUB); ld(5, I_HALT);
        go("t6r");
        chk("t6_mem", tos, 8'hBC);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
